pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage MIPS core. Detects load-use hazards that ID
//  forwarding cannot resolve and sequences multi-cycle MDU (mult/div) operations in EX.
//  Honours MEM bus stalls and exception flushes. Drives per-stage stall and flush controls
//  to the pc/if_id/id_ex/ex_mem/mem_wb registers.
// PARAMETERS
//  MDU_CYCLES   36  EX occupancy of one MDU op, in cycles (>=2)
//  PERF_W       32  width of the stall performance counter
// PORTS
//  clk               in   1       core clock
//  rst               in   1       reset
//  id_reg1_read_i    in   1       ID reads operand 1 from the regfile
//  id_reg1_addr_i    in   5       ID operand 1 register address
//  id_reg2_read_i    in   1       ID reads operand 2 from the regfile
//  id_reg2_addr_i    in   5       ID operand 2 register address
//  ex_is_load_i      in   1       instruction in EX is a load
//  ex_wreg_addr_i    in   5       destination register of the instruction in EX
//  ex_mdu_start_i    in   1       EX holds an MDU op; level, held while EX is stalled
//  mem_stall_req_i   in   1       MEM bus access not yet complete
//  exc_flush_i       in   1       exception or eret commit; kill pipeline
//  stall_o           out  6       Stall_t {wb,mem,ex,id,if,pc}; 1 = hold stage register
//  flush_o           out  1       clear all pipeline registers
//  mdu_busy_o        out  1       MDU sequence in progress
//  mdu_done_o        out  1       MDU result valid in EX this cycle
//  stall_cnt_o       out  PERF_W  stalled-cycle count (PIPE_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: rst is synchronous and active-high.
//    - State goes to S_IDLE. MDU counter is 0.
//    - stall_o=0, flush_o=0, mdu_busy_o=0, mdu_done_o=0, stall_cnt_o=0.
//  - FSM (registered) with states S_IDLE, S_MDU_RUN, S_MDU_DONE.
//    - S_IDLE -> S_MDU_RUN when ex_mdu_start_i && !mem_stall_req_i && !exc_flush_i.
//      The counter loads MDU_CYCLES-2.
//    - S_MDU_RUN: the counter decrements every cycle, including during a MEM stall.
//      At counter==0 -> S_MDU_DONE.
//    - S_MDU_DONE: mdu_done_o=1 and the EX stall is released.
//      Leaves to S_IDLE on the first cycle with !mem_stall_req_i.
//    - Total EX occupancy is MDU_CYCLES cycles: the start cycle, MDU_CYCLES-2 run cycles
//      and one done cycle.
//  - mdu_busy_o = (state==S_MDU_RUN) || (state==S_IDLE && MDU start condition).
//  - load_use = ex_is_load_i && ex_wreg_addr_i!=0 && ((id_reg1_read_i && id_reg1_addr_i==ex_wreg_addr_i)
//    || (id_reg2_read_i && id_reg2_addr_i==ex_wreg_addr_i)).
//  - stall_o is combinational. Priority, highest first:
//    - exc_flush_i        -> 6'b000000, flush_o=1
//    - mem_stall_req_i    -> 6'b011111 (WB receives a bubble)
//    - mdu_busy_o         -> 6'b001111 (MEM receives a bubble)
//    - load_use           -> 6'b000111 (EX receives a bubble)
//    - otherwise          -> 6'b000000
//  - Flush mid-MDU: the FSM goes to S_IDLE next cycle and the counter clears.
//    mdu_done_o is never raised for the killed op.
//  - A load-use hazard behind an active MDU op is covered by the MDU stall and needs no
//    extra cycles.
//  - An MDU start while mem_stall_req_i is high is deferred. EX holds the op, so the start
//    stays asserted.
//  - ex_mdu_start_i is ignored in S_MDU_DONE. A new op starts only after S_IDLE is re-entered.
// CONFIGURATION
//  - PIPE_PERF_CNT_EN defined: stall_cnt_o increments, saturating at all-ones, on every
//    cycle with stall_o!=0. It clears on rst only.
//  - PIPE_PERF_CNT_EN undefined: stall_cnt_o is tied to 0 and no counter register exists.
// STRUCTURE
//  - cpu_defines package:
//    - Stall_t (logic [5:0]) with STALL_NONE, STALL_LOADUSE, STALL_MDU, STALL_MEM constants.
//    - Pipe_state_t enum {S_IDLE, S_MDU_RUN, S_MDU_DONE}.
//  - One sub-module, mdu_timer: loadable down-counter with a zero flag, sized
//    $clog2(MDU_CYCLES).
//  - FSM, hazard logic and stall priority mux stay in pipe_ctrl.
// TESTING
//  - Load-use: ex_is_load=1, ex_wreg=5'd8, id_reg1_read=1, id_reg1_addr=8.
//    -> stall_o=6'b000111 for 1 cycle. The same pattern with ex_wreg=0 -> stall_o=0.
//  - MDU with MDU_CYCLES=4, start held:
//    -> stall_o=6'b001111 for 3 cycles, then mdu_done_o=1 with stall_o=0 on cycle 4.
//    -> state back in S_IDLE on cycle 5.
//  - MEM stall during S_MDU_DONE:
//    -> stall_o=6'b011111 and mdu_done_o held high until mem_stall_req drops.
//  - exc_flush asserted in cycle 2 of an MDU op:
//    -> flush_o=1 and stall_o=0 that cycle. Next cycle mdu_busy_o=0 and no mdu_done_o follows.
//  - rst asserted mid S_MDU_RUN -> all outputs 0 on the next edge, FSM in S_IDLE.
//  - PIPE_PERF_CNT_EN: 3 MDU stall cycles + 1 load-use cycle -> stall_cnt_o=4.
//    Without the macro, stall_cnt_o stays 0 throughout.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline sequencer (package cpu_defines).
//   Stall_t      : per-stage hold vector {wb,mem,ex,id,if,pc}, 1 = hold stage register
//   STALL_*      : stall patterns, each inserting a bubble into the first released stage
//   Pipe_state_t : MDU sequencing FSM states
package cpu_defines;

  typedef logic [5:0] Stall_t;

  localparam Stall_t STALL_NONE    = 6'b000000;
  localparam Stall_t STALL_LOADUSE = 6'b000111;
  localparam Stall_t STALL_MDU     = 6'b001111;
  localparam Stall_t STALL_MEM     = 6'b011111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MDU_RUN  = 2'd1,
    S_MDU_DONE = 2'd2
  } Pipe_state_t;

endpackage

// File: rtl/pipe_ctrl_timer.sv
// Purpose: loadable down-counter timing the run phase of an MDU op.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : clear counter to 0 (highest priority)
//   load_i       : load load_val_i
//   load_val_i   : value loaded on load_i
//   dec_i        : decrement (holds at 0)
//   zero_c       : combinational; the value the counter takes next edge is 0
module mdu_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count; the zero flag looks at the next value so the FSM can leave RUN
  // on the same edge the count reaches 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
    zero_c = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Purpose: pipeline sequencer for the 5-stage core. Detects load-use hazards,
//   sequences multi-cycle MDU ops in EX, honours MEM stalls and exception flushes.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   id_reg{1,2}_read_i/addr_i   : ID operand register reads
//   ex_is_load_i, ex_wreg_addr_i: EX load flag and destination register
//   ex_mdu_start_i              : EX holds an MDU op (level)
//   mem_stall_req_i             : MEM access not complete
//   exc_flush_i                 : exception/eret commit, kill pipeline
//   stall_o                     : {wb,mem,ex,id,if,pc} hold vector (combinational)
//   flush_o                     : clear all pipeline registers
//   mdu_busy_o, mdu_done_o      : MDU sequence in progress / result valid in EX
//   stall_cnt_o                 : stalled-cycle counter
// Configuration: define PIPE_PERF_CNT_EN to build the saturating stall counter;
//   otherwise stall_cnt_o is tied to 0.
module pipe_ctrl
  import cpu_defines::*;
#(
  parameter int unsigned MDU_CYCLES = 36,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_reg1_read_i,
  input  logic [4:0]        id_reg1_addr_i,
  input  logic              id_reg2_read_i,
  input  logic [4:0]        id_reg2_addr_i,
  input  logic              ex_is_load_i,
  input  logic [4:0]        ex_wreg_addr_i,
  input  logic              ex_mdu_start_i,
  input  logic              mem_stall_req_i,
  input  logic              exc_flush_i,
  output logic [5:0]        stall_o,
  output logic              flush_o,
  output logic              mdu_busy_o,
  output logic              mdu_done_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int unsigned     CNT_W    = $clog2(MDU_CYCLES);
  localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 2);
  // With MDU_CYCLES == 2 there are no run cycles: start goes straight to DONE.
  localparam logic            HAS_RUN  = (MDU_CYCLES > 2);

  Pipe_state_t state_q, state_d;
  logic        start_c;
  logic        load_use_c;
  logic        tmr_clr, tmr_load, tmr_dec, tmr_zero;

  mdu_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (MDU_LOAD),
    .dec_i      (tmr_dec),
    .zero_c     (tmr_zero)
  );

  // Next-state, timer control and hazard/stall outputs.
  always_comb begin
    state_d  = state_q;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;

    start_c    = ex_mdu_start_i && !mem_stall_req_i && !exc_flush_i;
    load_use_c = ex_is_load_i && (ex_wreg_addr_i != 5'd0) &&
                 ((id_reg1_read_i && (id_reg1_addr_i == ex_wreg_addr_i)) ||
                  (id_reg2_read_i && (id_reg2_addr_i == ex_wreg_addr_i)));

    if (exc_flush_i) begin
      state_d = S_IDLE;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            tmr_load = 1'b1;
            state_d  = HAS_RUN ? S_MDU_RUN : S_MDU_DONE;
          end
        end
        S_MDU_RUN: begin
          // Keeps counting through MEM stalls; the op itself is independent of MEM.
          tmr_dec = 1'b1;
          if (tmr_zero) begin
            state_d = S_MDU_DONE;
          end
        end
        S_MDU_DONE: begin
          if (!mem_stall_req_i) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    mdu_busy_o = !rst && ((state_q == S_MDU_RUN) || ((state_q == S_IDLE) && start_c));
    mdu_done_o = !rst && (state_q == S_MDU_DONE);
    flush_o    = !rst && exc_flush_i;

    // Priority stall mux; a load-use behind a busy MDU is absorbed by the MDU stall.
    if (rst || exc_flush_i) begin
      stall_o = STALL_NONE;
    end else if (mem_stall_req_i) begin
      stall_o = STALL_MEM;
    end else if (mdu_busy_o) begin
      stall_o = STALL_MDU;
    end else if (load_use_c) begin
      stall_o = STALL_LOADUSE;
    end else begin
      stall_o = STALL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles with any stage held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_o != STALL_NONE) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with MDU_CYCLES=4: a cycle-by-cycle vector
// table plus a stall-counter sequence.
module tb_pipe_ctrl;

  localparam int unsigned PERF_W = 32;

  logic              clk;
  logic              rst;
  logic              id_reg1_read_i;
  logic [4:0]        id_reg1_addr_i;
  logic              id_reg2_read_i;
  logic [4:0]        id_reg2_addr_i;
  logic              ex_is_load_i;
  logic [4:0]        ex_wreg_addr_i;
  logic              ex_mdu_start_i;
  logic              mem_stall_req_i;
  logic              exc_flush_i;
  logic [5:0]        stall_o;
  logic              flush_o;
  logic              mdu_busy_o;
  logic              mdu_done_o;
  logic [PERF_W-1:0] stall_cnt_o;

  pipe_ctrl #(.MDU_CYCLES(4), .PERF_W(PERF_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_reg1_read_i  (id_reg1_read_i),
    .id_reg1_addr_i  (id_reg1_addr_i),
    .id_reg2_read_i  (id_reg2_read_i),
    .id_reg2_addr_i  (id_reg2_addr_i),
    .ex_is_load_i    (ex_is_load_i),
    .ex_wreg_addr_i  (ex_wreg_addr_i),
    .ex_mdu_start_i  (ex_mdu_start_i),
    .mem_stall_req_i (mem_stall_req_i),
    .exc_flush_i     (exc_flush_i),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .mdu_busy_o      (mdu_busy_o),
    .mdu_done_o      (mdu_done_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [4:0] wa;
    logic       r1rd;
    logic [4:0] r1a;
    logic       r2rd;
    logic [4:0] r2a;
    logic       st;
    logic       ms;
    logic       fl;
    logic [5:0] e_stall;
    logic       e_flush;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(logic r, logic ld, logic [4:0] wa, logic r1rd, logic [4:0] r1a,
                              logic r2rd, logic [4:0] r2a, logic st, logic ms, logic fl,
                              logic [5:0] es, logic ef, logic eb, logic ed);
    vec_t v;
    v.rst = r;  v.ld = ld; v.wa = wa; v.r1rd = r1rd; v.r1a = r1a;
    v.r2rd = r2rd; v.r2a = r2a; v.st = st; v.ms = ms; v.fl = fl;
    v.e_stall = es; v.e_flush = ef; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle at the negedge, check outputs before the posedge, then advance.
  task automatic apply(input vec_t v, input int idx, input logic chk_cnt);
    rst             = v.rst;
    ex_is_load_i    = v.ld;
    ex_wreg_addr_i  = v.wa;
    id_reg1_read_i  = v.r1rd;
    id_reg1_addr_i  = v.r1a;
    id_reg2_read_i  = v.r2rd;
    id_reg2_addr_i  = v.r2a;
    ex_mdu_start_i  = v.st;
    mem_stall_req_i = v.ms;
    exc_flush_i     = v.fl;
    #1;
    chk("stall", idx, 32'(stall_o), 32'(v.e_stall));
    chk("flush", idx, 32'(flush_o), 32'(v.e_flush));
    chk("busy",  idx, 32'(mdu_busy_o), 32'(v.e_busy));
    chk("done",  idx, 32'(mdu_done_o), 32'(v.e_done));
    if (chk_cnt) chk("cnt_zero", idx, stall_cnt_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t vq[$];
  vec_t pq[$];
  logic cnt_off;

  initial begin
    rst = 1'b1; ex_is_load_i = 1'b0; ex_wreg_addr_i = '0; id_reg1_read_i = 1'b0;
    id_reg1_addr_i = '0; id_reg2_read_i = 1'b0; id_reg2_addr_i = '0;
    ex_mdu_start_i = 1'b0; mem_stall_req_i = 1'b0; exc_flush_i = 1'b0;
`ifdef PIPE_PERF_CNT_EN
    cnt_off = 1'b0;
`else
    cnt_off = 1'b1;
`endif

    //            rst ld wa    r1 r1a   r2 r2a   st ms fl   stall      fl bz dn
    vq.push_back(mk(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b000000, 0, 0, 0)); // 0 reset
    vq.push_back(mk(0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, 0, 0, 6'b000111, 0, 0, 0)); // 1 load-use r1
    vq.push_back(mk(0, 1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 2 r0 dest
    vq.push_back(mk(0, 1, 5'd3, 0, 5'd0, 1, 5'd3, 0, 0, 0, 6'b000111, 0, 0, 0)); // 3 load-use r2
    vq.push_back(mk(0, 1, 5'd3, 1, 5'd4, 0, 5'd3, 0, 0, 0, 6'b000000, 0, 0, 0)); // 4 no read
    vq.push_back(mk(0, 0, 5'd8, 1, 5'd8, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 5 not load
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0)); // 6 mdu start
    vq.push_back(mk(0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0)); // 7 run + load-use
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0)); // 8 run
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b000000, 0, 0, 1)); // 9 done
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 10 idle
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 6'b011111, 0, 0, 0)); // 11 start deferred
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0)); // 12 start
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 6'b011111, 0, 1, 0)); // 13 run, mem stall
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0)); // 14 run
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 6'b011111, 0, 0, 1)); // 15 done, mem stall
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 1, 0, 6'b011111, 0, 0, 1)); // 16 done held
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b000000, 0, 0, 1)); // 17 done released
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 18 idle
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0)); // 19 start
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 1, 6'b000000, 1, 1, 0)); // 20 flush in run
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 21 killed
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 22 no done
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 1, 6'b000000, 1, 0, 0)); // 23 flush blocks start
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 24 idle
    vq.push_back(mk(0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, 1, 1, 6'b000000, 1, 0, 0)); // 25 flush over all
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0)); // 26 start
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0)); // 27 run
    vq.push_back(mk(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 28 rst mid run
    vq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0)); // 29 idle, no done

    // Stall counter: 3 MDU stall cycles then 1 load-use cycle.
    pq.push_back(mk(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 0));
    pq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0));
    pq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0));
    pq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 6'b001111, 0, 1, 0));
    pq.push_back(mk(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 6'b000000, 0, 0, 1));
    pq.push_back(mk(0, 1, 5'd8, 1, 5'd8, 0, 5'd0, 0, 0, 0, 6'b000111, 0, 0, 0));

    @(negedge clk);
    foreach (vq[i]) apply(vq[i], i, cnt_off);
    foreach (pq[i]) apply(pq[i], 100 + i, cnt_off);

    // Now between the posedge after the load-use cycle and the next posedge.
    rst = 1'b0; ex_is_load_i = 1'b0; ex_wreg_addr_i = '0; id_reg1_read_i = 1'b0;
    id_reg1_addr_i = '0; ex_mdu_start_i = 1'b0;
    #1;
`ifdef PIPE_PERF_CNT_EN
    chk("stall_cnt", 200, stall_cnt_o, 32'd4);
`else
    chk("stall_cnt", 200, stall_cnt_o, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
